// File: rtl/ama_riscv_fe_sched.sv
// Frontend control-flow scheduler: sequences PC updates around unresolved
// branches and jumps, gates PC advance on imem readiness, and counts stall
// cycles. Optional static not-taken prediction: FE_SCHED_BP_NT_EN.

package ama_riscv_fe_sched_pkg;
  typedef enum logic {
    PC_SEL_INC4 = 1'b0,
    PC_SEL_ALU  = 1'b1
  } pc_sel_t;

  typedef struct packed {
    pc_sel_t pc_sel;
    logic    pc_we;
  } fe_ctrl_t;
endpackage

module ama_riscv_fe_sched
  import ama_riscv_fe_sched_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  fe_ctrl_t         dec_fe_ctrl,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             ex_br_res,
  input  logic             ex_br_taken,
  input  logic             ex_jmp_done,
  input  logic             imem_rdy,
  output pc_sel_t          pc_sel,
  output logic             pc_we,
  output logic             dec_bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    JMP_WAIT = 2'd2
`ifdef FE_SCHED_BP_NT_EN
    , BR_SPEC = 2'd3
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic             pending_reg, pending_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign stall_cnt = stall_cnt_reg;

  // Output decode and next-state selection; outputs forced safe while in reset
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    pc_sel       = PC_SEL_INC4;
    pc_we        = 1'b0;
    dec_bubble   = 1'b1;
    flush        = 1'b0;
    if (rst) begin
      case (state_reg)
        RUN: begin
          pc_sel     = dec_fe_ctrl.pc_sel;
          pc_we      = dec_fe_ctrl.pc_we & imem_rdy;
          dec_bubble = ~(dec_fe_ctrl.pc_we & imem_rdy);
          if (dec_valid && dec_jump) begin
            pc_we      = 1'b0;
            dec_bubble = 1'b1;
            state_next = JMP_WAIT;
          end else if (dec_valid && dec_branch) begin
`ifdef FE_SCHED_BP_NT_EN
            // Predict not-taken; only enter speculation once the branch advanced
            pc_sel     = PC_SEL_INC4;
            pc_we      = imem_rdy;
            dec_bubble = ~imem_rdy;
            if (imem_rdy) state_next = BR_SPEC;
`else
            pc_we      = 1'b0;
            dec_bubble = 1'b1;
            state_next = BR_WAIT;
`endif
          end
        end
        JMP_WAIT: begin
          // EX keeps ex_jmp_done high until the redirect is accepted
          if (ex_jmp_done) begin
            pc_sel = PC_SEL_ALU;
            pc_we  = imem_rdy;
            if (imem_rdy) state_next = RUN;
          end
        end
        BR_WAIT: begin
          if (pending_reg) begin
            // Taken target was latched earlier; EX holds it until accepted
            pc_sel = PC_SEL_ALU;
            pc_we  = imem_rdy;
            if (imem_rdy) begin
              pending_next = 1'b0;
              state_next   = RUN;
            end
          end else if (ex_br_res) begin
            pc_sel = ex_br_taken ? PC_SEL_ALU : PC_SEL_INC4;
            pc_we  = imem_rdy;
            if (imem_rdy) begin
              state_next = RUN;
            end else if (ex_br_taken) begin
              pending_next = 1'b1;
            end else begin
              // Not-taken needs no target: sequential fetch resumes from RUN
              state_next = RUN;
            end
          end
        end
`ifdef FE_SCHED_BP_NT_EN
        BR_SPEC: begin
          pc_sel     = PC_SEL_INC4;
          pc_we      = imem_rdy;
          dec_bubble = ~imem_rdy;
          if (ex_br_res && ex_br_taken) begin
            flush      = 1'b1;
            pc_sel     = PC_SEL_ALU;
            dec_bubble = 1'b1;
            if (imem_rdy) begin
              state_next = RUN;
            end else begin
              pending_next = 1'b1;
              state_next   = BR_WAIT;
            end
          end else if (ex_br_res) begin
            // Not-taken: a new branch in decode becomes the next speculation
            if (dec_valid && dec_jump) begin
              pc_we      = 1'b0;
              dec_bubble = 1'b1;
              state_next = RUN;
            end else if (dec_valid && dec_branch) begin
              if (!imem_rdy) state_next = RUN;
            end else begin
              state_next = RUN;
            end
          end else if (dec_valid && (dec_branch || dec_jump)) begin
            pc_we      = 1'b0;
            dec_bubble = 1'b1;
          end
        end
`endif
        default: state_next = RUN;
      endcase
    end
  end

  // State, redirect-pending flag and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      pending_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (!pc_we && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_fe_sched.sv
// Directed bench for ama_riscv_fe_sched: RUN-state vector table plus
// hand-written jump/branch/reset/saturation sequences.
module tb_ama_riscv_fe_sched;
  import ama_riscv_fe_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, dec_valid, dec_branch, dec_jump, ex_br_res, ex_br_taken, ex_jmp_done, imem_rdy;
  fe_ctrl_t dec_fe_ctrl;
  pc_sel_t pc_sel, pc_sel4;
  logic pc_we, dec_bubble, flush, pc_we4, bub4, flush4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  int total = 0;
  int bad = 0;

  ama_riscv_fe_sched #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_fe_ctrl(dec_fe_ctrl),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .ex_br_res(ex_br_res),
    .ex_br_taken(ex_br_taken), .ex_jmp_done(ex_jmp_done), .imem_rdy(imem_rdy),
    .pc_sel(pc_sel), .pc_we(pc_we), .dec_bubble(dec_bubble), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  ama_riscv_fe_sched #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_fe_ctrl(dec_fe_ctrl),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .ex_br_res(ex_br_res),
    .ex_br_taken(ex_br_taken), .ex_jmp_done(ex_jmp_done), .imem_rdy(imem_rdy),
    .pc_sel(pc_sel4), .pc_we(pc_we4), .dec_bubble(bub4), .flush(flush4),
    .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic v, sel, we, br, jp, res, rdy;
    logic e_sel, e_we, e_bub;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic drive(input logic v, sel, we, br, jp, res, tk, jd, rdy);
    dec_valid          = v;
    dec_fe_ctrl.pc_sel = pc_sel_t'(sel);
    dec_fe_ctrl.pc_we  = we;
    dec_branch         = br;
    dec_jump           = jp;
    ex_br_res          = res;
    ex_br_taken        = tk;
    ex_jmp_done        = jd;
    imem_rdy           = rdy;
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  // ADD-like sequential instruction in decode with imem ready
  task automatic idle;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    idle();
    to_pos();
    to_pos();
    rst = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    rst = 1'b0;
    idle();

    // Reset with random inputs: outputs forced, counter held at zero
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_bubble", dec_bubble, 1);
      chk("rst_flush", flush, 0);
      chk("rst_pc_sel", pc_sel, PC_SEL_INC4);
      chk("rst_cnt", stall_cnt, 0);
      to_pos();
    end
    rst = 1'b1;

    // RUN-state vectors that never leave RUN
    //           v  sel we br jp res rdy  e_sel e_we e_bub
    tbl[0] = '{1, 0, 1, 0, 0, 0, 1,  0, 1, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 1};
    tbl[2] = '{1, 1, 1, 0, 0, 0, 1,  1, 1, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 0, 1,  0, 0, 1};
    tbl[4] = '{0, 0, 1, 1, 0, 0, 1,  0, 1, 0};
    tbl[5] = '{0, 1, 1, 0, 1, 0, 1,  1, 1, 0};
    tbl[6] = '{1, 0, 1, 0, 0, 1, 1,  0, 1, 0};
    tbl[7] = '{1, 1, 1, 0, 0, 0, 0,  1, 0, 1};
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].we, tbl[i].br, tbl[i].jp,
            tbl[i].res, tbl[i].res, tbl[i].res, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_pc_sel", i), pc_sel, tbl[i].e_sel);
      chk($sformatf("vec%0d_pc_we", i), pc_we, tbl[i].e_we);
      chk($sformatf("vec%0d_bubble", i), dec_bubble, tbl[i].e_bub);
      chk($sformatf("vec%0d_cnt", i), stall_cnt, exp_cnt);
      if (!tbl[i].e_we) exp_cnt++;
      to_pos();
    end

    // JAL in decode, target ready one cycle later
    do_reset();
    drive(1, 1, 1, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    chk("jal_pc_we", pc_we, 0);
    chk("jal_bubble", dec_bubble, 1);
    to_pos();
    drive(0, 0, 1, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    chk("jal_done_sel", pc_sel, PC_SEL_ALU);
    chk("jal_done_we", pc_we, 1);
    to_pos();
    idle();
    @(negedge clk);
    chk("jal_after_we", pc_we, 1);
    chk("jal_cnt", stall_cnt, 1);
    to_pos();

`ifndef FE_SCHED_BP_NT_EN
    // Branch taken with imem not ready for 3 cycles: target must be kept
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("br_c0_we", pc_we, 0);
    chk("br_c0_bubble", dec_bubble, 1);
    to_pos();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("br_c1_we", pc_we, 0);
    to_pos();
    drive(0, 0, 1, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    chk("br_c2_we", pc_we, 0);
    to_pos();
    for (int i = 3; i < 5; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("br_c%0d_we", i), pc_we, 0);
      to_pos();
    end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("br_c5_sel", pc_sel, PC_SEL_ALU);
    chk("br_c5_we", pc_we, 1);
    to_pos();
    idle();
    @(negedge clk);
    chk("br_after_sel", pc_sel, PC_SEL_INC4);
    chk("br_cnt", stall_cnt, 5);
    to_pos();
`else
    // Predicted not-taken, resolved not-taken: no bubble, no flush
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("bp_nt_c0_we", pc_we, 1);
    chk("bp_nt_c0_bubble", dec_bubble, 0);
    to_pos();
    drive(1, 0, 1, 0, 0, 1, 0, 0, 1);
    @(negedge clk);
    chk("bp_nt_c1_we", pc_we, 1);
    chk("bp_nt_c1_bubble", dec_bubble, 0);
    chk("bp_nt_c1_flush", flush, 0);
    to_pos();
    // Resolved taken: single flush cycle with ALU redirect
    drive(1, 0, 1, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("bp_t_c0_flush", flush, 0);
    to_pos();
    drive(1, 0, 1, 0, 0, 1, 1, 0, 1);
    @(negedge clk);
    chk("bp_t_c1_flush", flush, 1);
    chk("bp_t_c1_sel", pc_sel, PC_SEL_ALU);
    chk("bp_t_c1_we", pc_we, 1);
    to_pos();
    idle();
    @(negedge clk);
    chk("bp_t_c2_flush", flush, 0);
    chk("bp_t_c2_sel", pc_sel, PC_SEL_INC4);
    to_pos();
`endif

    // Reset pulsed while waiting on a branch aborts the wait
    do_reset();
    drive(1, 0, 1, 1, 0, 0, 0, 0, 1);
    to_pos();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_cnt", stall_cnt, 0);
    chk("rstmid_we", pc_we, 0);
    to_pos();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 1, 1, 0, 1);
    @(negedge clk);
    chk("rstmid_after_sel", pc_sel, PC_SEL_INC4);
    chk("rstmid_after_we", pc_we, 1);
    chk("rstmid_after_flush", flush, 0);
    to_pos();

    // Saturation of a 4-bit counter with imem held not ready for 20 cycles
    do_reset();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        @(negedge clk);
        chk("sat4_at15", stall_cnt4, 15);
      end
      to_pos();
    end
    @(negedge clk);
    chk("sat4_at20", stall_cnt4, 15);
    chk("cnt32_at20", stall_cnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
